// File: rtl/feeder_pkg.sv
// ---------------------------------------------------------------------------
// feeder_pkg
// Shared types and sizing helpers for the conv stream feeder.
//   - feeder_state_e : top-level control states (IDLE, LOAD, RUN)
//   - ifm_depth / wgt_depth : memory depths derived from the conv geometry
//   - ptr_width : address width for a given depth (never below 1 bit)
//   - pad_size / IFM_PAD : padded frame edge length, used when the
//     FEEDER_PAD_EN build option is defined
// ---------------------------------------------------------------------------
package feeder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } feeder_state_e;

    function automatic int ifm_depth(input int ci, input int size);
        return ci * size * size;
    endfunction

    function automatic int wgt_depth(input int co, input int ci, input int ksize);
        return co * ci * ksize * ksize;
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int pad_size(input int size, input int pad);
        return size + 2 * pad;
    endfunction

    // Padded frame edge for the default geometry (28 + 2*2).
    localparam int IFM_PAD = pad_size(28, 2);

endpackage

// File: rtl/feeder_ram.sv
// ---------------------------------------------------------------------------
// feeder_ram
// Simple one-write / one-read synchronous RAM with a registered read port.
// Contents are not reset; the read register only updates when rd_en_i is
// high, so the owner must qualify rd_data_o with its own valid flag.
// Ports:
//   clk2       in  clock
//   wr_en_i    in  write enable
//   wr_addr_i  in  write address
//   wr_data_i  in  write data
//   rd_en_i    in  read enable
//   rd_addr_i  in  read address
//   rd_data_o  out read data, one cycle after rd_en_i
// ---------------------------------------------------------------------------
module feeder_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk2,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Storage and registered read; no reset so it maps onto block RAM.
    always_ff @(posedge clk2) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/conv_stream_feeder.sv
// ---------------------------------------------------------------------------
// conv_stream_feeder
// On-chip feeder for the conv accelerator's ifm and weight streams. A host
// load port fills two local memories; the accelerator's read strobes are
// answered one cycle later with data, valid and end-of-frame wrap flags.
//
// Build option: FEEDER_PAD_EN
//   defined   - ifm stream emits a zero-padded frame (IFM_SIZE+2*PAD square
//               per channel); border reads return 0 with ifm_valid high and
//               do not advance the memory address.
//   undefined - PAD is ignored; an ifm frame is CI*IFM_SIZE^2 reads.
//
// Ports:
//   clk2, rst_n          clock, asynchronous active-low reset
//   start_conv           start / restart streams, clears read pointers
//   end_conv             leave RUN (start_conv wins if both high)
//   ld_valid/ld_sel/ld_data, ld_ready, load_err   host load port
//   ifm_read -> ifm, ifm_valid, ifm_wrap          ifm stream
//   wgt_read -> wgt, wgt_valid, wgt_wrap          weight stream
//   busy                 high while in RUN
// ---------------------------------------------------------------------------
module conv_stream_feeder
    import feeder_pkg::*;
#(
    parameter int IFM_WIDTH    = 16,
    parameter int WEIGHT_WIDTH = 16,
    parameter int IFM_SIZE     = 28,
    parameter int KERNEL_SIZE  = 5,
    parameter int PAD          = 2,
    parameter int CI           = 3,
    parameter int CO           = 8,
    parameter int LD_WIDTH     = 16
) (
    input  logic                    clk2,
    input  logic                    rst_n,
    input  logic                    start_conv,
    input  logic                    end_conv,
    input  logic                    ld_valid,
    input  logic                    ld_sel,
    input  logic [LD_WIDTH-1:0]     ld_data,
    output logic                    ld_ready,
    output logic                    load_err,
    input  logic                    ifm_read,
    output logic [IFM_WIDTH-1:0]    ifm,
    output logic                    ifm_valid,
    output logic                    ifm_wrap,
    input  logic                    wgt_read,
    output logic [WEIGHT_WIDTH-1:0] wgt,
    output logic                    wgt_valid,
    output logic                    wgt_wrap,
    output logic                    busy
);

    localparam int IFM_DEPTH = ifm_depth(CI, IFM_SIZE);
    localparam int WGT_DEPTH = wgt_depth(CO, CI, KERNEL_SIZE);
    localparam int IFM_AW    = ptr_width(IFM_DEPTH);
    localparam int WGT_AW    = ptr_width(WGT_DEPTH);

    localparam logic [IFM_AW-1:0] IFM_LAST = IFM_AW'(IFM_DEPTH - 1);
    localparam logic [WGT_AW-1:0] WGT_LAST = WGT_AW'(WGT_DEPTH - 1);

    feeder_state_e state_q, state_d;

    logic [IFM_AW-1:0] ifm_wr_ptr_q, ifm_wr_ptr_d;
    logic [WGT_AW-1:0] wgt_wr_ptr_q, wgt_wr_ptr_d;
    logic [IFM_AW-1:0] ifm_rd_ptr_q, ifm_rd_ptr_d;
    logic [WGT_AW-1:0] wgt_rd_ptr_q, wgt_rd_ptr_d;

    logic ifm_valid_q, ifm_wrap_q, ifm_border_q;
    logic wgt_valid_q, wgt_wrap_q;
    logic load_err_q;

    logic is_run, enter_run, wr_accept, ifm_we, wgt_we;
    logic ifm_rd_en, wgt_rd_en, ifm_ram_re;
    logic ifm_border, ifm_frame_last;
    logic [IFM_AW-1:0] ifm_rd_addr;
    logic [WGT_AW-1:0] wgt_rd_addr;
    logic [IFM_WIDTH-1:0]    ifm_rdata;
    logic [WEIGHT_WIDTH-1:0] wgt_rdata;

    // Control FSM: state register.
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Control FSM: next state. start_conv takes priority over end_conv so a
    // restart in RUN never drops back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_conv) begin
                    state_d = RUN;
                end else if (ld_valid) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (start_conv) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (end_conv && !start_conv) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign is_run    = (state_q == RUN);
    assign enter_run = (state_d == RUN) && !is_run;
    assign ld_ready  = !is_run;
    assign busy      = is_run;

    // Load words are accepted in IDLE as well as LOAD, so the first word of a
    // burst is not lost while the FSM moves out of IDLE.
    assign wr_accept = ld_valid && !is_run;
    assign ifm_we    = wr_accept && !ld_sel;
    assign wgt_we    = wr_accept && ld_sel;

    // Write pointers: wrap at depth, cleared when RUN is entered so the next
    // load session starts at entry 0.
    always_comb begin
        ifm_wr_ptr_d = ifm_wr_ptr_q;
        wgt_wr_ptr_d = wgt_wr_ptr_q;
        if (enter_run) begin
            ifm_wr_ptr_d = '0;
            wgt_wr_ptr_d = '0;
        end else begin
            if (ifm_we) begin
                ifm_wr_ptr_d = (ifm_wr_ptr_q == IFM_LAST) ? '0 : ifm_wr_ptr_q + IFM_AW'(1);
            end
            if (wgt_we) begin
                wgt_wr_ptr_d = (wgt_wr_ptr_q == WGT_LAST) ? '0 : wgt_wr_ptr_q + WGT_AW'(1);
            end
        end
    end

    // A read coinciding with start_conv is served from entry 0.
    assign wgt_rd_en   = wgt_read && is_run;
    assign wgt_rd_addr = start_conv ? '0 : wgt_rd_ptr_q;

    always_comb begin
        wgt_rd_ptr_d = wgt_rd_ptr_q;
        if (wgt_rd_en) begin
            wgt_rd_ptr_d = (wgt_rd_addr == WGT_LAST) ? '0 : wgt_rd_addr + WGT_AW'(1);
        end else if (start_conv) begin
            wgt_rd_ptr_d = '0;
        end
    end

    assign ifm_rd_en = ifm_read && is_run;

`ifdef FEEDER_PAD_EN
    localparam int PADDED = pad_size(IFM_SIZE, PAD);
    localparam int PW     = ptr_width(PADDED);
    localparam int CW     = ptr_width(CI);
    localparam logic [PW-1:0] POS_LAST = PW'(PADDED - 1);
    localparam logic [PW-1:0] INNER_LO = PW'(PAD);
    localparam logic [PW-1:0] INNER_HI = PW'(PAD + IFM_SIZE);
    localparam logic [CW-1:0] CH_LAST  = CW'(CI - 1);

    logic [CW-1:0] ch_q, ch_d, ch_cur;
    logic [PW-1:0] row_q, row_d, row_cur;
    logic [PW-1:0] col_q, col_d, col_cur;

    assign ch_cur      = start_conv ? '0 : ch_q;
    assign row_cur     = start_conv ? '0 : row_q;
    assign col_cur     = start_conv ? '0 : col_q;
    assign ifm_rd_addr = start_conv ? '0 : ifm_rd_ptr_q;

    assign ifm_border     = (row_cur < INNER_LO) || (row_cur >= INNER_HI) ||
                            (col_cur < INNER_LO) || (col_cur >= INNER_HI);
    assign ifm_frame_last = (ch_cur == CH_LAST) && (row_cur == POS_LAST) &&
                            (col_cur == POS_LAST);
    assign ifm_ram_re     = ifm_rd_en && !ifm_border;

    // Raster walk over channel/row/column of the padded frame; the memory
    // address only moves on interior positions.
    always_comb begin
        ch_d         = ch_q;
        row_d        = row_q;
        col_d        = col_q;
        ifm_rd_ptr_d = ifm_rd_ptr_q;
        if (ifm_rd_en) begin
            if (ifm_frame_last) begin
                ch_d         = '0;
                row_d        = '0;
                col_d        = '0;
                ifm_rd_ptr_d = '0;
            end else begin
                ch_d  = ch_cur;
                row_d = row_cur;
                col_d = col_cur + PW'(1);
                if (col_cur == POS_LAST) begin
                    col_d = '0;
                    row_d = row_cur + PW'(1);
                    if (row_cur == POS_LAST) begin
                        row_d = '0;
                        ch_d  = ch_cur + CW'(1);
                    end
                end
                ifm_rd_ptr_d = ifm_border ? ifm_rd_addr : ifm_rd_addr + IFM_AW'(1);
            end
        end else if (start_conv) begin
            ch_d         = '0;
            row_d        = '0;
            col_d        = '0;
            ifm_rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            ch_q  <= '0;
            row_q <= '0;
            col_q <= '0;
        end else begin
            ch_q  <= ch_d;
            row_q <= row_d;
            col_q <= col_d;
        end
    end
`else
    assign ifm_rd_addr    = start_conv ? '0 : ifm_rd_ptr_q;
    assign ifm_border     = 1'b0;
    assign ifm_frame_last = (ifm_rd_addr == IFM_LAST);
    assign ifm_ram_re     = ifm_rd_en;

    always_comb begin
        ifm_rd_ptr_d = ifm_rd_ptr_q;
        if (ifm_rd_en) begin
            ifm_rd_ptr_d = ifm_frame_last ? '0 : ifm_rd_addr + IFM_AW'(1);
        end else if (start_conv) begin
            ifm_rd_ptr_d = '0;
        end
    end
`endif

    // Pointer and stream-flag registers. Flags are registered alongside the
    // RAM read so data, valid and wrap line up one cycle after the strobe.
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            ifm_wr_ptr_q <= '0;
            wgt_wr_ptr_q <= '0;
            ifm_rd_ptr_q <= '0;
            wgt_rd_ptr_q <= '0;
            ifm_valid_q  <= 1'b0;
            ifm_wrap_q   <= 1'b0;
            ifm_border_q <= 1'b0;
            wgt_valid_q  <= 1'b0;
            wgt_wrap_q   <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            ifm_wr_ptr_q <= ifm_wr_ptr_d;
            wgt_wr_ptr_q <= wgt_wr_ptr_d;
            ifm_rd_ptr_q <= ifm_rd_ptr_d;
            wgt_rd_ptr_q <= wgt_rd_ptr_d;
            ifm_valid_q  <= ifm_rd_en;
            ifm_wrap_q   <= ifm_rd_en && ifm_frame_last;
            ifm_border_q <= ifm_rd_en && ifm_border;
            wgt_valid_q  <= wgt_rd_en;
            wgt_wrap_q   <= wgt_rd_en && (wgt_rd_addr == WGT_LAST);
            load_err_q   <= ld_valid && is_run;
        end
    end

    feeder_ram #(
        .WIDTH (IFM_WIDTH),
        .DEPTH (IFM_DEPTH),
        .AW    (IFM_AW)
    ) u_ifm_ram (
        .clk2      (clk2),
        .wr_en_i   (ifm_we),
        .wr_addr_i (ifm_wr_ptr_q),
        .wr_data_i (ld_data[IFM_WIDTH-1:0]),
        .rd_en_i   (ifm_ram_re),
        .rd_addr_i (ifm_rd_addr),
        .rd_data_o (ifm_rdata)
    );

    feeder_ram #(
        .WIDTH (WEIGHT_WIDTH),
        .DEPTH (WGT_DEPTH),
        .AW    (WGT_AW)
    ) u_wgt_ram (
        .clk2      (clk2),
        .wr_en_i   (wgt_we),
        .wr_addr_i (wgt_wr_ptr_q),
        .wr_data_i (ld_data[WEIGHT_WIDTH-1:0]),
        .rd_en_i   (wgt_rd_en),
        .rd_addr_i (wgt_rd_addr),
        .rd_data_o (wgt_rdata)
    );

    // RAM read registers hold stale data; gate with valid (and border) so
    // idle cycles and padding positions present zero.
    assign ifm       = (ifm_valid_q && !ifm_border_q) ? ifm_rdata : '0;
    assign ifm_valid = ifm_valid_q;
    assign ifm_wrap  = ifm_wrap_q;
    assign wgt       = wgt_valid_q ? wgt_rdata : '0;
    assign wgt_valid = wgt_valid_q;
    assign wgt_wrap  = wgt_wrap_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_conv_stream_feeder.sv
// ---------------------------------------------------------------------------
// tb_conv_stream_feeder
// Directed self-checking bench for conv_stream_feeder with default
// parameters. Honours FEEDER_PAD_EN for the expected ifm frame contents.
// ---------------------------------------------------------------------------
module tb_conv_stream_feeder;

    localparam int IFM_DEPTH = 2352;
    localparam int WGT_DEPTH = 600;
`ifdef FEEDER_PAD_EN
    localparam int FRAME = 3 * 32 * 32;
`else
    localparam int FRAME = IFM_DEPTH;
`endif

    logic        clk2;
    logic        rst_n;
    logic        start_conv, end_conv;
    logic        ld_valid, ld_sel;
    logic [15:0] ld_data;
    logic        ld_ready, load_err;
    logic        ifm_read, ifm_valid, ifm_wrap;
    logic [15:0] ifm;
    logic        wgt_read, wgt_valid, wgt_wrap;
    logic [15:0] wgt;
    logic        busy;

    int errCount;
    int checkCount;

    conv_stream_feeder dut (
        .clk2       (clk2),
        .rst_n      (rst_n),
        .start_conv (start_conv),
        .end_conv   (end_conv),
        .ld_valid   (ld_valid),
        .ld_sel     (ld_sel),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .load_err   (load_err),
        .ifm_read   (ifm_read),
        .ifm        (ifm),
        .ifm_valid  (ifm_valid),
        .ifm_wrap   (ifm_wrap),
        .wgt_read   (wgt_read),
        .wgt        (wgt),
        .wgt_valid  (wgt_valid),
        .wgt_wrap   (wgt_wrap),
        .busy       (busy)
    );

    // Free-running clock.
    initial clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    // Count one comparison and report it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive all inputs, then advance one clock and settle 1ns past the edge.
    task automatic applyStimulus(input logic sc, input logic ec, input logic lv,
                                 input logic ls, input logic [15:0] ld,
                                 input logic ir, input logic wr);
        start_conv = sc;
        end_conv   = ec;
        ld_valid   = lv;
        ld_sel     = ls;
        ld_data    = ld;
        ifm_read   = ir;
        wgt_read   = wr;
        @(posedge clk2);
        #1;
    endtask

    // Expected ifm word for read number k of the stream (memory holds ifm[i]=i).
    function automatic int expIfm(input int k);
        int p;
`ifdef FEEDER_PAD_EN
        int ch, row, col;
        p   = k % FRAME;
        ch  = p / 1024;
        row = (p % 1024) / 32;
        col = p % 32;
        if (row < 2 || row >= 30 || col < 2 || col >= 30) return 0;
        return ch * 784 + (row - 2) * 28 + (col - 2);
`else
        p = k % FRAME;
        return p;
`endif
    endfunction

    initial begin
        errCount   = 0;
        checkCount = 0;
        rst_n      = 1'b0;
        applyStimulus(0, 0, 0, 0, 16'd0, 0, 0);
        applyStimulus(0, 0, 0, 0, 16'd0, 0, 0);

        $display("[TB] reset state");
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ld_ready", ld_ready, 1);
        checkOutput("rst_ifm_valid", ifm_valid, 0);
        checkOutput("rst_wgt_valid", wgt_valid, 0);
        checkOutput("rst_load_err", load_err, 0);

        rst_n = 1'b1;
        #2;

        $display("[TB] loading memories");
        for (int i = 0; i < IFM_DEPTH; i++) begin
            applyStimulus(0, 0, 1, 0, 16'(i), 0, 0);
        end
        checkOutput("load_ready", ld_ready, 1);
        for (int i = 0; i < WGT_DEPTH; i++) begin
            applyStimulus(0, 0, 1, 1, 16'(i), 0, 0);
        end
        checkOutput("load_busy", busy, 0);

        $display("[TB] full ifm frame");
        applyStimulus(1, 0, 0, 0, 16'd0, 0, 0);
        checkOutput("run_busy", busy, 1);
        checkOutput("run_ld_ready", ld_ready, 0);
        for (int k = 0; k < FRAME; k++) begin
            applyStimulus(0, 0, 0, 0, 16'd0, 1, 0);
            checkOutput("ifm_data", ifm, expIfm(k));
            checkOutput("ifm_valid", ifm_valid, 1);
            checkOutput("ifm_wrap", ifm_wrap, (k == FRAME - 1) ? 1 : 0);
        end
        applyStimulus(0, 0, 0, 0, 16'd0, 1, 0);
        checkOutput("ifm_after_wrap", ifm, expIfm(0));
        checkOutput("ifm_after_wrap_flag", ifm_wrap, 0);
        applyStimulus(0, 0, 0, 0, 16'd0, 0, 0);
        checkOutput("ifm_idle_valid", ifm_valid, 0);
        checkOutput("ifm_idle_data", ifm, 0);

        $display("[TB] alternating weight reads");
        for (int j = 0; j < 2 * WGT_DEPTH; j++) begin
            applyStimulus(0, 0, 0, 0, 16'd0, 0, (j % 2 == 0) ? 1'b1 : 1'b0);
            if (j % 2 == 0) begin
                checkOutput("wgt_data", wgt, j / 2);
                checkOutput("wgt_valid", wgt_valid, 1);
                checkOutput("wgt_wrap", wgt_wrap, (j / 2 == WGT_DEPTH - 1) ? 1 : 0);
            end else begin
                checkOutput("wgt_idle_data", wgt, 0);
                checkOutput("wgt_idle_valid", wgt_valid, 0);
            end
        end

        $display("[TB] restart at ifm pointer 100");
        for (int k = 1; k < 100; k++) begin
            applyStimulus(0, 0, 0, 0, 16'd0, 1, 0);
            checkOutput("ifm_walk", ifm, expIfm(k));
        end
        applyStimulus(1, 0, 0, 0, 16'd0, 1, 0);
        checkOutput("restart_first", ifm, expIfm(0));
        checkOutput("restart_first_valid", ifm_valid, 1);
        applyStimulus(0, 0, 0, 0, 16'd0, 1, 0);
        checkOutput("restart_second", ifm, expIfm(1));
        applyStimulus(0, 0, 0, 0, 16'd0, 0, 0);

        $display("[TB] load attempt during RUN");
        applyStimulus(0, 0, 1, 0, 16'hBEEF, 0, 0);
        checkOutput("run_load_ready", ld_ready, 0);
        checkOutput("load_err_pulse", load_err, 1);
        applyStimulus(0, 0, 0, 0, 16'd0, 0, 0);
        checkOutput("load_err_clear", load_err, 0);
        applyStimulus(1, 0, 0, 0, 16'd0, 1, 1);
        checkOutput("mem_unchanged_ifm", ifm, expIfm(0));
        checkOutput("mem_unchanged_wgt", wgt, 0);
        applyStimulus(0, 0, 0, 0, 16'd0, 1, 1);
        checkOutput("mem_unchanged_ifm1", ifm, expIfm(1));
        checkOutput("mem_unchanged_wgt1", wgt, 1);
        applyStimulus(0, 1, 0, 0, 16'd0, 0, 0);
        checkOutput("end_busy", busy, 0);
        checkOutput("end_ld_ready", ld_ready, 1);
        applyStimulus(0, 0, 0, 0, 16'd0, 1, 1);
        checkOutput("idle_read_valid", ifm_valid, 0);
        checkOutput("idle_read_wvalid", wgt_valid, 0);

        $display("[TB] start and end together");
        applyStimulus(1, 1, 0, 0, 16'd0, 0, 0);
        checkOutput("start_end_idle", busy, 1);
        applyStimulus(1, 1, 0, 0, 16'd0, 0, 0);
        checkOutput("start_end_run", busy, 1);

        $display("[TB] reset mid-RUN");
        applyStimulus(0, 0, 0, 0, 16'd0, 1, 1);
        applyStimulus(0, 0, 0, 0, 16'd0, 1, 1);
        checkOutput("pre_reset_valid", ifm_valid, 1);
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 16'd0, 1, 1);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_ld_ready", ld_ready, 1);
        checkOutput("mid_rst_ifm", ifm, 0);
        checkOutput("mid_rst_ifm_valid", ifm_valid, 0);
        checkOutput("mid_rst_ifm_wrap", ifm_wrap, 0);
        checkOutput("mid_rst_wgt", wgt, 0);
        checkOutput("mid_rst_wgt_valid", wgt_valid, 0);
        checkOutput("mid_rst_wgt_wrap", wgt_wrap, 0);
        rst_n = 1'b1;
        #2;
        applyStimulus(0, 0, 0, 0, 16'd0, 1, 0);
        checkOutput("post_rst_read_valid", ifm_valid, 0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
